membus_interconnect: RTL and testbench

Parametrised memory-bus interconnect between the single-cycle CPU core and its data-side targets. It generalises the fixed RAM/device split to one internal word RAM plus NUM_DEV memory-mapped device channels. Each device channel uses a ready handshake, so a device may take multiple cycles to answer. While a device access is outstanding, the block stalls the CPU. A device that never answers is cut off by a timeout, and unmapped or timed-out accesses are reported as bus errors.

---
 rtl/membus_interconnect.sv | 184 ++++++++++++++++++
 tb/tb_membus_interconnect.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/membus_interconnect.sv
// Data-side bus interconnect: internal word RAM plus NUM_DEV ready-handshake
// device channels with CPU stall, timeout abort and bus-error reporting.
module membus_interconnect #(
    parameter int                DATA_W        = 32,
    parameter int                ADDR_W        = 32,
    parameter int                RAM_WORDS     = 256,
    parameter logic [ADDR_W-1:0] DEV_BASE      = 32'h40000000,
    parameter int                DEV_SPAN_BITS = 8,
    parameter int                NUM_DEV       = 4,
    parameter int                TIMEOUT       = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cpu_read,
    input  logic                      cpu_write,
    input  logic [ADDR_W-1:0]         cpu_addr,
    input  logic [DATA_W-1:0]         cpu_wdata,
    output logic [DATA_W-1:0]         cpu_rdata,
    output logic                      cpu_stall,
    output logic                      cpu_err,
    output logic [NUM_DEV-1:0]        dev_sel,
    output logic                      dev_read,
    output logic                      dev_write,
    output logic [DEV_SPAN_BITS-1:0]  dev_addr,
    output logic [DATA_W-1:0]         dev_wdata,
    input  logic [NUM_DEV*DATA_W-1:0] dev_rdata,
    input  logic [NUM_DEV-1:0]        dev_ready
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int IDX_W  = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEV_WAIT = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]        rdata_q, rdata_d;
    logic                     err_q, err_d;
    logic [NUM_DEV-1:0]       sel_q, sel_d;
    logic                     rd_q, rd_d;
    logic                     wr_q, wr_d;
    logic [DEV_SPAN_BITS-1:0] off_q, off_d;
    logic [DATA_W-1:0]        wd_q, wd_d;

    logic [DATA_W-1:0] mem [RAM_WORDS];
    logic [RAM_AW-1:0] ram_idx;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_we;

    logic              req;
    logic              is_ram;
    logic [ADDR_W-1:0] rel;
    logic [ADDR_W-1:0] idx_full;
    logic              mapped;
    logic [DATA_W-1:0] chan_rdata;

    assign req       = cpu_read | cpu_write;
    assign is_ram    = cpu_addr < DEV_BASE;
    assign rel       = cpu_addr - DEV_BASE;
    assign idx_full  = rel >> DEV_SPAN_BITS;
    assign mapped    = idx_full < ADDR_W'(NUM_DEV);
    assign ram_idx   = cpu_addr[RAM_AW+1:2];
    assign ram_rdata = mem[ram_idx];
    assign chan_rdata = dev_rdata[idx_q*DATA_W +: DATA_W];

    // Strobes and channel fields come straight from flops so they never glitch
    assign dev_sel   = sel_q;
    assign dev_read  = rd_q;
    assign dev_write = wr_q;
    assign dev_addr  = off_q;
    assign dev_wdata = wd_q;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_idx] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            sel_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            off_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            sel_q   <= sel_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            off_q   <= off_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        sel_d     = sel_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        off_d     = off_q;
        wd_d      = wd_q;
        cpu_stall = 1'b0;
        cpu_err   = 1'b0;
        cpu_rdata = '0;
        ram_we    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cpu_read && is_ram) begin
                    cpu_rdata = ram_rdata;
                end
                if (req && is_ram) begin
                    ram_we = cpu_write;
                end else if (req && !mapped) begin
                    cpu_rdata = '0;
                    cpu_err   = 1'b1;
                end else if (req) begin
                    cpu_stall = 1'b1;
                    cpu_rdata = '0;
                    idx_d     = idx_full[IDX_W-1:0];
                    off_d     = rel[DEV_SPAN_BITS-1:0];
                    wd_d      = cpu_wdata;
                    wr_d      = cpu_write;
                    rd_d      = ~cpu_write;
                    sel_d     = NUM_DEV'(1) << idx_full[IDX_W-1:0];
                    cnt_d     = '0;
                    state_d   = DEV_WAIT;
                end
            end
            DEV_WAIT: begin
                cpu_stall = 1'b1;
                if (dev_ready[idx_q] || cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Ready wins over a timeout landing in the same cycle
                    rdata_d = (dev_ready[idx_q] && !wr_q) ? chan_rdata : '0;
                    err_d   = ~dev_ready[idx_q];
                    sel_d   = '0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    off_d   = '0;
                    wd_d    = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                cpu_rdata = rdata_q;
                cpu_err   = err_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (reset) begin
            cpu_stall = 1'b0;
            cpu_err   = 1'b0;
            ram_we    = 1'b0;
        end
    end

endmodule

// File: tb/tb_membus_interconnect.sv
// Directed bench for membus_interconnect: RAM, device wait, unmapped,
// write priority, timeout, ready isolation and asynchronous reset.
module tb_membus_interconnect;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_read;
    logic         cpu_write;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_stall;
    logic         cpu_err;
    logic [3:0]   dev_sel;
    logic         dev_read;
    logic         dev_write;
    logic [7:0]   dev_addr;
    logic [31:0]  dev_wdata;
    logic [127:0] dev_rdata;
    logic [3:0]   dev_ready;

    int total = 0;
    int bad   = 0;
    int n;

    membus_interconnect dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .cpu_err   (cpu_err),
        .dev_sel   (dev_sel),
        .dev_read  (dev_read),
        .dev_write (dev_write),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_rdata (dev_rdata),
        .dev_ready (dev_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        dev_rdata = '0;
        dev_ready = '0;

        step();
        step();
        #2;
        chk("rst_sel", 64'(dev_sel), 64'h0);
        chk("rst_strobes", 64'({dev_read, dev_write}), 64'h0);
        chk("rst_addr", 64'(dev_addr), 64'h0);
        chk("rst_wdata", 64'(dev_wdata), 64'h0);
        chk("rst_stall_err", 64'({cpu_stall, cpu_err}), 64'h0);
        chk("rst_rdata", 64'(cpu_rdata), 64'h0);

        step();
        reset = 1'b0;

        // RAM round trip
        cpu_write = 1'b1;
        cpu_addr  = 32'h0000_0010;
        cpu_wdata = 32'hDEADBEEF;
        #2;
        chk("ram_wr_stall", 64'(cpu_stall), 64'h0);
        step();
        cpu_write = 1'b0;
        cpu_read  = 1'b1;
        #2;
        chk("ram_rd", 64'(cpu_rdata), 64'hDEADBEEF);
        chk("ram_rd_stall", 64'(cpu_stall), 64'h0);
        step();
        cpu_addr = 32'h0000_0410;
        #2;
        chk("ram_alias", 64'(cpu_rdata), 64'hDEADBEEF);

        // Device 1 read, ready on 3rd wait cycle
        step();
        cpu_addr = 32'h4000_0104;
        #2;
        chk("dev1_req_stall", 64'(cpu_stall), 64'h1);
        chk("dev1_req_nosel", 64'(dev_sel), 64'h0);
        step();
        #2;
        chk("dev1_w1", 64'({cpu_stall, dev_read, dev_write, dev_sel, dev_addr}),
            64'({1'b1, 1'b1, 1'b0, 4'b0010, 8'h04}));
        step();
        #2;
        chk("dev1_w2", 64'({cpu_stall, dev_read, dev_sel, dev_addr}),
            64'({1'b1, 1'b1, 4'b0010, 8'h04}));
        step();
        dev_ready = 4'b0010;
        dev_rdata[32 +: 32] = 32'h12345678;
        #2;
        chk("dev1_w3", 64'({cpu_stall, dev_read, dev_sel, dev_addr}),
            64'({1'b1, 1'b1, 4'b0010, 8'h04}));
        step();
        dev_ready = 4'b0000;
        #2;
        chk("dev1_done_rdata", 64'(cpu_rdata), 64'h12345678);
        chk("dev1_done_flags", 64'({cpu_stall, cpu_err, dev_read, dev_sel}),
            64'h0);
        step();
        cpu_read = 1'b0;

        // Unmapped read
        cpu_read = 1'b1;
        cpu_addr = 32'h4000_0400;
        #2;
        chk("unmap", 64'({cpu_err, cpu_stall, dev_read, dev_write, dev_sel}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 4'b0000}));
        chk("unmap_rdata", 64'(cpu_rdata), 64'h0);

        // Read+write priority to device 0, with ready isolation
        step();
        cpu_write = 1'b1;
        cpu_addr  = 32'h4000_0008;
        cpu_wdata = 32'hA5A5A5A5;
        step();
        dev_ready = 4'b1000;
        #2;
        chk("prio_strobe", 64'({dev_write, dev_read, dev_sel, dev_addr}),
            64'({1'b1, 1'b0, 4'b0001, 8'h08}));
        chk("prio_wdata", 64'(dev_wdata), 64'hA5A5A5A5);
        step();
        dev_ready = 4'b0000;
        #2;
        chk("iso_still_wait", 64'({cpu_stall, dev_write, dev_sel}),
            64'({1'b1, 1'b1, 4'b0001}));
        step();
        dev_ready = 4'b0001;
        #2;
        chk("iso_w3", 64'(cpu_stall), 64'h1);
        step();
        dev_ready = 4'b0000;
        #2;
        chk("iso_done", 64'({cpu_stall, cpu_err, dev_write}), 64'h0);
        chk("iso_done_rdata", 64'(cpu_rdata), 64'h0);
        step();
        cpu_read  = 1'b0;
        cpu_write = 1'b0;

        // Timeout on device 2 write
        cpu_write = 1'b1;
        cpu_addr  = 32'h4000_0210;
        cpu_wdata = 32'h0BADF00D;
        step();
        n = 0;
        #2;
        while (dev_write && n < 40) begin
            if (cpu_stall !== 1'b1 || dev_sel !== 4'b0100) begin
                chk("tmo_wait_flags", 64'({cpu_stall, dev_sel}),
                    64'({1'b1, 4'b0100}));
            end
            n++;
            step();
            #2;
        end
        chk("tmo_waits", 64'(n), 64'd15);
        chk("tmo_done", 64'({cpu_err, cpu_stall, dev_write, dev_sel}),
            64'({1'b1, 1'b0, 1'b0, 4'b0000}));
        step();
        cpu_write = 1'b0;
        #2;
        chk("tmo_idle", 64'({cpu_err, cpu_stall, dev_write, dev_read, dev_sel}),
            64'h0);

        // Reset mid-access on device 3
        step();
        cpu_read = 1'b1;
        cpu_addr = 32'h4000_0300;
        step();
        step();
        #1;
        chk("rst_pre_sel", 64'({dev_read, dev_sel}), 64'({1'b1, 4'b1000}));
        reset = 1'b1;
        #1;
        chk("rst_async_drop", 64'({dev_read, dev_write, dev_sel}), 64'h0);
        chk("rst_async_stall", 64'({cpu_stall, cpu_err}), 64'h0);
        step();
        reset    = 1'b0;
        cpu_read = 1'b0;
        #2;
        chk("rst_after", 64'({cpu_stall, cpu_err, dev_sel}), 64'h0);
        step();
        cpu_read = 1'b1;
        cpu_addr = 32'h0000_0010;
        #2;
        chk("rst_ram_keep", 64'(cpu_rdata), 64'hDEADBEEF);
        step();
        cpu_read = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
